// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and register index width.
package rv_pkg;
  localparam int REG_W = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR: return IMM_I;
      STORE:              return IMM_S;
      BRANCH:             return IMM_B;
      LUI, AUIPC:         return IMM_U;
      JAL:                return IMM_J;
      default:            return IMM_NONE;
    endcase
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID inputs, register-file/writeback nets and ID/EX register outputs.
interface id_ex_stage_if #(parameter int DATA_W = 32, parameter int STALL_CNT_W = 16);
  import rv_pkg::*;

  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [DATA_W-1:0] id_pc;
  logic              flush;
  logic [REG_W-1:0]  rf_read_regA;
  logic [REG_W-1:0]  rf_read_regB;
  logic [DATA_W-1:0] rf_read_dataA;
  logic [DATA_W-1:0] rf_read_dataB;
  logic              wb_write_enable;
  logic [REG_W-1:0]  wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_instr;
  logic [REG_W-1:0]  ex_rs1;
  logic [REG_W-1:0]  ex_rs2;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_opA;
  logic [DATA_W-1:0] ex_opB;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_is_load;
  logic              ex_reg_write;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_instr, id_pc, flush, rf_read_dataA, rf_read_dataB,
           wb_write_enable, wb_write_reg, wb_write_data,
    input  rf_read_regA, rf_read_regB, stall, ex_valid, ex_pc, ex_instr, ex_rs1, ex_rs2,
           ex_rd, ex_opA, ex_opB, ex_imm, ex_is_load, ex_reg_write, stall_count
  );

  modport slave (
    input  id_valid, id_instr, id_pc, flush, rf_read_dataA, rf_read_dataB,
           wb_write_enable, wb_write_reg, wb_write_data,
    output rf_read_regA, rf_read_regB, stall, ex_valid, ex_pc, ex_instr, ex_rs1, ex_rs2,
           ex_rd, ex_opA, ex_opB, ex_imm, ex_is_load, ex_reg_write, stall_count
  );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational immediate generator for the RV32I I/S/B/U/J formats.
module imm_gen
  import rv_pkg::*;
#(parameter int DATA_W = 32)
(
  input  logic [DATA_W-1:0]        instr,
  output logic signed [DATA_W-1:0] imm
);
  always_comb begin
    imm = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: operand read with writeback bypass, load-use interlock,
// and the ID/EX pipeline register.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
)(
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic [6:0]               opc_p0;
  logic [REG_W-1:0]         rs1_p0, rs2_p0, rd_p0;
  logic                     uses_rs1_p0, uses_rs2_p0, writes_rd_p0;
  logic                     hazard_p0;
  logic signed [DATA_W-1:0] imm_p0, opa_p0, opb_p0;

  logic                     vld_p1;
  logic [DATA_W-1:0]        pc_p1, instr_p1;
  logic [REG_W-1:0]         rs1_p1, rs2_p1, rd_p1;
  logic signed [DATA_W-1:0] opa_p1, opb_p1, imm_p1;
  logic                     is_load_p1, reg_write_p1;
  logic [STALL_CNT_W-1:0]   stall_cnt_p1;

  // Register file reads old data on a collision, so the in-flight write is bypassed here.
  function automatic logic signed [DATA_W-1:0] bypass(
    input logic [REG_W-1:0]  rs,
    input logic              we,
    input logic [REG_W-1:0]  wr,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] rf
  );
    if (rs == '0)           return '0;
    if (we && (wr == rs))   return wd;
    return rf;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign opc_p0 = bus.id_instr[6:0];
  assign rd_p0  = bus.id_instr[11:7];
  assign rs1_p0 = bus.id_instr[19:15];
  assign rs2_p0 = bus.id_instr[24:20];

  always_comb begin
    uses_rs1_p0  = 1'b0;
    uses_rs2_p0  = 1'b0;
    writes_rd_p0 = 1'b0;
    case (opc_p0)
      OP:            begin uses_rs1_p0 = 1'b1; uses_rs2_p0 = 1'b1; writes_rd_p0 = 1'b1; end
      OP_IMM, LOAD,
      JALR:          begin uses_rs1_p0 = 1'b1; writes_rd_p0 = 1'b1; end
      STORE, BRANCH: begin uses_rs1_p0 = 1'b1; uses_rs2_p0 = 1'b1; end
      LUI, AUIPC,
      JAL:           writes_rd_p0 = 1'b1;
      default:       ;
    endcase
  end

  imm_gen #(.DATA_W(DATA_W)) u_imm_gen (.instr(bus.id_instr), .imm(imm_p0));

  assign opa_p0 = bypass(rs1_p0, bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data,
                         bus.rf_read_dataA);
  assign opb_p0 = bypass(rs2_p0, bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data,
                         bus.rf_read_dataB);

  assign hazard_p0 = vld_p1 && is_load_p1 && (rd_p1 != '0) && bus.id_valid && !bus.flush &&
                     ((uses_rs1_p0 && (rs1_p0 == rd_p1)) || (uses_rs2_p0 && (rs2_p0 == rd_p1)));

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      instr_p1     <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      opa_p1       <= '0;
      opb_p1       <= '0;
      imm_p1       <= '0;
      is_load_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      stall_cnt_p1 <= '0;
    end else begin
      vld_p1   <= bus.id_valid && !bus.flush && !hazard_p0;
      pc_p1    <= bus.id_pc;
      instr_p1 <= bus.id_instr;
      rs1_p1   <= rs1_p0;
      rs2_p1   <= rs2_p0;
      rd_p1    <= rd_p0;
      opa_p1   <= opa_p0;
      opb_p1   <= opb_p0;
      imm_p1   <= imm_p0;
      // A bubble must not look like a load, or the held instruction would stall again.
      is_load_p1   <= !hazard_p0 && (opc_p0 == LOAD);
      reg_write_p1 <= !hazard_p0 && writes_rd_p0 && (rd_p0 != '0) && bus.id_valid;
      if (hazard_p0) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.rf_read_regA = rs1_p0;
  assign bus.rf_read_regB = rs2_p0;
  assign bus.stall        = hazard_p0;
  assign bus.ex_valid     = vld_p1;
  assign bus.ex_pc        = pc_p1;
  assign bus.ex_instr     = instr_p1;
  assign bus.ex_rs1       = rs1_p1;
  assign bus.ex_rs2       = rs2_p1;
  assign bus.ex_rd        = rd_p1;
  assign bus.ex_opA       = opa_p1;
  assign bus.ex_opB       = opb_p1;
  assign bus.ex_imm       = imm_p1;
  assign bus.ex_is_load   = is_load_p1;
  assign bus.ex_reg_write = reg_write_p1;
  assign bus.stall_count  = stall_cnt_p1;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the decode/issue rules.
module tb_id_ex_stage;
  import rv_pkg::*;

  localparam int CW     = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .STALL_CNT_W(CW)) bus ();
  id_ex_stage #(.DATA_W(32), .STALL_CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        valid;
    logic        bubble;
    logic [31:0] pc, instr, opA, opB, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        is_load, reg_write;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Model of what EX currently holds.
  logic m_valid = 1'b0;
  logic m_is_load = 1'b0;
  logic [4:0] m_rd = '0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction classes and immediates straight from the ISA field layout.
  task automatic decode(input logic [31:0] i, output bit r1, output bit r2, output bit wr,
                        output logic [31:0] imm);
    logic [31:0] sx;
    byte kind;
    sx = $signed(i) >>> 31;
    case (i[6:0])
      OP:     begin r1 = 1; r2 = 1; wr = 1; kind = "R"; end
      OP_IMM: begin r1 = 1; r2 = 0; wr = 1; kind = "I"; end
      LOAD:   begin r1 = 1; r2 = 0; wr = 1; kind = "I"; end
      JALR:   begin r1 = 1; r2 = 0; wr = 1; kind = "I"; end
      STORE:  begin r1 = 1; r2 = 1; wr = 0; kind = "S"; end
      BRANCH: begin r1 = 1; r2 = 1; wr = 0; kind = "B"; end
      JAL:    begin r1 = 0; r2 = 0; wr = 1; kind = "J"; end
      LUI:    begin r1 = 0; r2 = 0; wr = 1; kind = "U"; end
      AUIPC:  begin r1 = 0; r2 = 0; wr = 1; kind = "U"; end
      default: begin r1 = 0; r2 = 0; wr = 0; kind = "-"; end
    endcase
    case (kind)
      "I": imm = $signed(i) >>> 20;
      "S": imm = ((sx << 11)) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
      "B": imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      "U": imm = i & 32'hFFFF_F000;
      "J": imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: imm = 32'h0;
    endcase
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd,
                                          input logic [31:0] rf);
    if (rs == 0) return 32'h0;
    return (we && wr == rs) ? wd : rf;
  endfunction

  // One issue attempt per cycle; a stalled instruction is re-presented by upstream.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic [31:0] ra, input logic [31:0] rb,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    bit st, r1, r2, wrd;
    int tries;
    logic [31:0] imm;
    exp_t e;
    tries = 0;
    do begin
      @(negedge clk);
      bus.id_valid = v; bus.id_instr = ins; bus.id_pc = pc; bus.flush = fl;
      bus.rf_read_dataA = ra; bus.rf_read_dataB = rb;
      bus.wb_write_enable = we; bus.wb_write_reg = wr; bus.wb_write_data = wd;
      #1;
      decode(ins, r1, r2, wrd, imm);
      st = m_valid && m_is_load && m_rd != 0 && v && !fl &&
           ((r1 && ins[19:15] == m_rd) || (r2 && ins[24:20] == m_rd));
      chk("stall", {31'b0, bus.stall}, {31'b0, st});
      chk("rf_read_regA", {27'b0, bus.rf_read_regA}, {27'b0, ins[19:15]});
      chk("rf_read_regB", {27'b0, bus.rf_read_regB}, {27'b0, ins[24:20]});
      e.valid = v && !fl && !st;
      e.bubble = st;
      e.pc = pc; e.instr = ins; e.imm = imm;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.opA = operand(ins[19:15], we, wr, wd, ra);
      e.opB = operand(ins[24:20], we, wr, wd, rb);
      e.is_load = !st && ins[6:0] == LOAD;
      e.reg_write = !st && wrd && ins[11:7] != 0 && v;
      if (st && m_cnt < CNT_MAX) m_cnt++;
      e.cnt = m_cnt;
      q.push_back(e);
      m_valid = e.valid; m_is_load = e.is_load; m_rd = e.rd;
      tries++;
    end while (st && tries < 3);
    if (st) begin
      miscompares++;
      $display("FAIL stall_bound: stall still 1 after %0d cycles, required release", tries);
    end
  endtask

  // Scoreboard monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, e.valid});
        chk("stall_count", 32'(bus.stall_count), 32'(e.cnt));
        if (e.valid) begin
          chk("ex_pc", bus.ex_pc, e.pc);
          chk("ex_instr", bus.ex_instr, e.instr);
          chk("ex_rs1", {27'b0, bus.ex_rs1}, {27'b0, e.rs1});
          chk("ex_rs2", {27'b0, bus.ex_rs2}, {27'b0, e.rs2});
          chk("ex_rd", {27'b0, bus.ex_rd}, {27'b0, e.rd});
          chk("ex_opA", bus.ex_opA, e.opA);
          chk("ex_opB", bus.ex_opB, e.opB);
          chk("ex_imm", bus.ex_imm, e.imm);
          chk("ex_is_load", {31'b0, bus.ex_is_load}, {31'b0, e.is_load});
          chk("ex_reg_write", {31'b0, bus.ex_reg_write}, {31'b0, e.reg_write});
        end else if (e.bubble) begin
          chk("bubble_is_load", {31'b0, bus.ex_is_load}, 32'h0);
          chk("bubble_reg_write", {31'b0, bus.ex_reg_write}, 32'h0);
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, 7'b0001111};
    logic [31:0] i;
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 9)];
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  task automatic rand_inputs();
    bus.id_valid = 1'($urandom); bus.id_instr = rand_instr(); bus.id_pc = $urandom;
    bus.flush = 1'($urandom); bus.rf_read_dataA = $urandom; bus.rf_read_dataB = $urandom;
    bus.wb_write_enable = 1'($urandom); bus.wb_write_reg = 5'($urandom);
    bus.wb_write_data = $urandom;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ex_valid"}, {31'b0, bus.ex_valid}, 32'h0);
    chk({tag, "_ex_pc"}, bus.ex_pc, 32'h0);
    chk({tag, "_ex_instr"}, bus.ex_instr, 32'h0);
    chk({tag, "_ex_rd"}, {27'b0, bus.ex_rd}, 32'h0);
    chk({tag, "_ex_opA"}, bus.ex_opA, 32'h0);
    chk({tag, "_ex_imm"}, bus.ex_imm, 32'h0);
    chk({tag, "_ex_is_load"}, {31'b0, bus.ex_is_load}, 32'h0);
    chk({tag, "_ex_reg_write"}, {31'b0, bus.ex_reg_write}, 32'h0);
    chk({tag, "_stall"}, {31'b0, bus.stall}, 32'h0);
    chk({tag, "_stall_count"}, 32'(bus.stall_count), 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    m_valid = 0; m_is_load = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] LW_X6   = 32'h0000A303;
  localparam logic [31:0] ADD_767 = 32'h001303B3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rand_inputs();
      #1;
      check_cleared("reset");
    end
    release_reset();

    step(1, 32'hFFF00093, 32'h100, 0, $urandom, $urandom, 0, 0, 0);               // addi x1,x0,-1
    step(1, 32'h006281B3, 32'h104, 0, 32'h11111111, 32'h22222222, 1, 5, 32'hDEADBEEF);
    step(1, 32'h006281B3, 32'h108, 0, 32'h11111111, 32'h22222222, 1, 0, 32'hDEADBEEF);
    step(1, 32'h006001B3, 32'h10C, 0, 32'hFFFFFFFF, 32'h33333333, 1, 0, 32'h5);
    step(1, LW_X6, 32'h110, 0, 32'h1000, 0, 0, 0, 0);
    step(1, ADD_767, 32'h114, 0, 32'h44, 32'h55, 0, 0, 0);
    step(1, LW_X6, 32'h118, 0, 32'h1000, 0, 0, 0, 0);
    step(1, 32'h00612023, 32'h11C, 0, 32'h2000, 32'h66, 0, 0, 0);                 // sw x6
    step(1, LW_X6, 32'h120, 0, 32'h1000, 0, 0, 0, 0);
    step(1, 32'h12345337, 32'h124, 0, 0, 0, 0, 0, 0);                            // lui x6
    step(1, LW_X6, 32'h128, 0, 32'h1000, 0, 0, 0, 0);
    step(1, ADD_767, 32'h12C, 1, 32'h44, 32'h55, 0, 0, 0);                        // flushed
    for (int k = 0; k < 5; k++) begin
      step(1, LW_X6, 32'h200 + 8 * k, 0, $urandom, $urandom, 0, 0, 0);
      step(1, ADD_767, 32'h204 + 8 * k, 0, $urandom, $urandom, 0, 0, 0);
    end

    // Asynchronous reset while a load-use stall is pending.
    step(1, LW_X6, 32'h300, 0, 32'h1000, 0, 0, 0, 0);
    drain();
    @(negedge clk);
    bus.id_valid = 1; bus.id_instr = ADD_767; bus.flush = 0;
    #1;
    chk("pre_reset_stall", {31'b0, bus.stall}, 32'h1);
    reset = 1'b0;
    #1;
    check_cleared("async");
    release_reset();

    for (int k = 0; k < 400; k++)
      step(($urandom % 8) != 0, rand_instr(), $urandom, ($urandom % 10) == 0,
           $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    drain();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage between the IF/ID register and EX.
- Drives the register file read addresses from the instruction in ID and bypasses same-cycle writeback data; the register file reads old data on a write/read collision.
- Generates immediates, detects load-use hazards (stall plus bubble) and registers everything into the ID/EX pipeline register consumed by EX.

Parameters:
- DATA_W, 32, operand/PC/instruction width; only 32 is supported.
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- id_valid  in  1  ID slot holds a real instruction.
- id_instr  in  32  instruction in ID.
- id_pc  in  32  PC of id_instr.
- flush  in  1  branch/jump redirect from EX; kill the ID instruction.
- rf_read_regA  out  5  = id_instr[19:15], combinational.
- rf_read_regB  out  5  = id_instr[24:20], combinational.
- rf_read_dataA  in  32  register file port A data.
- rf_read_dataB  in  32  register file port B data.
- wb_write_enable  in  1  writeback write strobe (same net as the register file write_enable).
- wb_write_reg  in  5  writeback destination.
- wb_write_data  in  32  writeback data.
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  EX slot valid.
- ex_pc  out  32  registered PC.
- ex_instr  out  32  registered instruction.
- ex_rs1  out  5  registered source register 1 (for EX forwarding).
- ex_rs2  out  5  registered source register 2 (for EX forwarding).
- ex_rd  out  5  registered destination = instr[11:7].
- ex_opA  out  32  registered, bypassed rs1 value.
- ex_opB  out  32  registered, bypassed rs2 value.
- ex_imm  out  32  registered, sign-extended immediate.
- ex_is_load  out  1  registered; opcode 0000011.
- ex_reg_write  out  1  registered; instruction writes rd and rd != 0.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, async): every ex_* output = 0 (ex_valid=0), stall_count=0. stall evaluates to 0 because ex_valid=0.
- Decode (combinational, from id_instr[6:0]):
  - uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: OP, STORE, BRANCH.
  - writes_rd: LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD.
  - Immediate by type:
    - I: instr[31:20] sign-extended.
    - S: {instr[31:25], instr[11:7]} sign-extended.
    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
    - U: {instr[31:12], 12'b0}.
    - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
    - Unknown opcode: 0.
- Operand select (opA; opB is symmetric with rs2):
  - rs1 == 0 gives 0, with top priority.
  - Otherwise, if wb_write_enable and wb_write_reg == rs1, use wb_write_data.
  - Otherwise use rf_read_dataA.
- Load-use hazard: stall = ex_valid & ex_is_load & ex_rd != 0 & id_valid & !flush & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- Posedge update, in priority order:
  - flush: ex_valid <= 0. Other ex_* fields are don't-care but are loaded normally.
  - stall: ex_valid <= 0 (bubble); ex_is_load <= 0 and ex_reg_write <= 0. Upstream holds, so the instruction re-presents next cycle and issues once the load has left EX; the stall lasts exactly 1 cycle.
  - otherwise: ex_valid <= id_valid; all ex_* fields <= decoded values; ex_reg_write = writes_rd & rd != 0 & id_valid.
- stall_count increments by 1 on each posedge where stall = 1 and saturates at all-ones.
- Latency: 1 cycle from ID to EX outputs. No stalls other than load-use.
- Reset asserted mid-stall clears the bubble state; the first cycle after reset release never stalls.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - imm_type enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - register index width 5.
- One combinational sub-module, imm_gen (instr in, imm out). Hazard logic and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: hold reset=0 with random inputs -> all ex_* = 0, stall = 0, stall_count = 0; after release, addi x1,x0,-1 (0xFFF00093) -> next cycle ex_valid=1, ex_rd=1, ex_imm=0xFFFFFFFF, ex_opA=0, ex_reg_write=1.
- WB bypass: id add x3,x5,x6 with rf A data 0x11111111, while wb writes x5=0xDEADBEEF in the same cycle -> ex_opA=0xDEADBEEF, ex_opB = rf B data. Same test with wb_write_reg=0 -> no bypass.
- x0: rs1=0, rf_read_dataA=0xFFFFFFFF, wb writes x0=5 -> ex_opA=0.
- Load-use: EX holds lw x6; ID holds add x7,x6,x1 -> stall=1 for one cycle, then ex_valid=0 (bubble), then add issues with ex_valid=1; stall_count=1. sw x6 (rs2=x6) also stalls; lui x6 does not.
- Flush during hazard: same hazard with flush=1 -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
- Saturation: STALL_CNT_W=2, five consecutive load-use pairs -> stall_count reaches 3 and holds at 3.
